// File: rtl/e203_subsys_rtc_tickgen.sv
// e203_subsys_rtc_tickgen
// ----------------------------------------------------------------------------
// Programmable real-time-clock tick generator with an ICB register port.
// A DIV_W-bit prescaler counts 0..DIV. Each time it wraps, rtc_toggle inverts
// and the 32-bit TICKS counter increments. rtc_toggle drives the CLINT
// rtcToggle input.
//
// Register map (decoded on addr[3:2] when addr[11:4] == 0):
//   0x0 CTRL  : bit0 = en, other bits read 0
//   0x4 DIV   : bits[DIV_W-1:0] divisor (writing it restarts the prescaler)
//   0x8 CNT   : read-only prescaler value (writes are ignored, no error)
//   0xC TICKS : toggle count; any write clears it
// Accesses with addr[11:4] != 0 return err=1 and rdata=0, with no side effect.
//
// Ports:
//   clk, rst_n           : clock and synchronous active-low reset
//   tick_icb_cmd_*       : command channel (valid/ready/addr/read/wdata/wmask)
//   tick_icb_rsp_*       : response channel (valid/ready/err/rdata)
//   tm_stop              : freezes the prescaler while high
//   rtc_toggle           : registered square-wave tick output
//
// Handshake: a command is accepted on any edge where cmd_valid & cmd_ready.
// cmd_ready = ~rsp_valid | rsp_ready, so at most one response is ever
// outstanding. The response becomes valid on the edge after the accept.
// Its data and error bits are captured from the register state as it was
// before that edge. They hold steady until rsp_valid & rsp_ready. A write
// updates its register on the accept edge itself.
// ----------------------------------------------------------------------------
module e203_subsys_rtc_tickgen #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] RST_DIV = 16'd511
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_icb_cmd_valid,
  output logic        tick_icb_cmd_ready,
  input  logic [31:0] tick_icb_cmd_addr,
  input  logic        tick_icb_cmd_read,
  input  logic [31:0] tick_icb_cmd_wdata,
  input  logic [3:0]  tick_icb_cmd_wmask,
  output logic        tick_icb_rsp_valid,
  input  logic        tick_icb_rsp_ready,
  output logic        tick_icb_rsp_err,
  output logic [31:0] tick_icb_rsp_rdata,
  input  logic        tm_stop,
  output logic        rtc_toggle
);

  logic             en;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [31:0]      ticks;
  logic             toggle_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;

  logic             accept;
  logic             in_range;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_div;
  logic             wr_ticks;
  logic             adv;
  logic             hit;
  logic [31:0]      div_ext;
  logic [31:0]      cnt_ext;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // Byte mask, the upper address bits, the low address bits and the wdata
  // bits above DIV_W play no part in decoding.
  assign unused_bits = ^{tick_icb_cmd_wmask, tick_icb_cmd_addr[31:12],
                         tick_icb_cmd_addr[1:0], tick_icb_cmd_wdata};

  assign tick_icb_cmd_ready = ~rsp_valid_q | tick_icb_rsp_ready;
  assign accept             = tick_icb_cmd_valid & tick_icb_cmd_ready;
  assign in_range           = (tick_icb_cmd_addr[11:4] == 8'd0);
  assign wr                 = accept & ~tick_icb_cmd_read & in_range;
  assign wr_ctrl            = wr & (tick_icb_cmd_addr[3:2] == 2'd0);
  assign wr_div             = wr & (tick_icb_cmd_addr[3:2] == 2'd1);
  assign wr_ticks           = wr & (tick_icb_cmd_addr[3:2] == 2'd3);

  // A DIV write restarts the prescaler from zero. It suppresses the
  // advance, and therefore any toggle, on that edge.
  assign hit = (cnt == div);
  assign adv = en & ~tm_stop & ~wr_div;

  always_comb begin
    div_ext              = '0;
    div_ext[DIV_W-1:0]   = div;
    cnt_ext              = '0;
    cnt_ext[DIV_W-1:0]   = cnt;
    rd_mux               = '0;
    if (in_range) begin
      case (tick_icb_cmd_addr[3:2])
        2'd0:    rd_mux = {31'd0, en};
        2'd1:    rd_mux = div_ext;
        2'd2:    rd_mux = cnt_ext;
        default: rd_mux = ticks;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en          <= 1'b0;
      div         <= RST_DIV;
      cnt         <= '0;
      ticks       <= '0;
      toggle_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // The current edge still uses the old en; the new value applies
      // from the next edge.
      if (wr_ctrl) en <= tick_icb_cmd_wdata[0];
      if (wr_div)  div <= tick_icb_cmd_wdata[DIV_W-1:0];

      if (wr_div)         cnt <= '0;
      else if (adv)       cnt <= hit ? '0 : cnt + 1'b1;

      if (adv && hit) toggle_q <= ~toggle_q;

      // A clear that lands on a tick edge wins over the increment.
      if (wr_ticks)         ticks <= '0;
      else if (adv && hit)  ticks <= ticks + 32'd1;

      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= ~in_range;
        rsp_rdata_q <= rd_mux;
      end else if (tick_icb_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign tick_icb_rsp_valid = rsp_valid_q;
  assign tick_icb_rsp_err   = rsp_err_q;
  assign tick_icb_rsp_rdata = rsp_rdata_q;
  assign rtc_toggle         = toggle_q;

endmodule

// File: tb/tb_e203_subsys_rtc_tickgen.sv
// Directed bench for e203_subsys_rtc_tickgen. All driving and sampling
// happens 1 ns after a rising clock edge.
module tb_e203_subsys_rtc_tickgen;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        tm_stop;
  logic        rtc_toggle;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  e203_subsys_rtc_tickgen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .tick_icb_cmd_valid (cmd_valid),
    .tick_icb_cmd_ready (cmd_ready),
    .tick_icb_cmd_addr  (cmd_addr),
    .tick_icb_cmd_read  (cmd_read),
    .tick_icb_cmd_wdata (cmd_wdata),
    .tick_icb_cmd_wmask (cmd_wmask),
    .tick_icb_rsp_valid (rsp_valid),
    .tick_icb_rsp_ready (rsp_ready),
    .tick_icb_rsp_err   (rsp_err),
    .tick_icb_rsp_rdata (rsp_rdata),
    .tm_stop            (tm_stop),
    .rtc_toggle         (rtc_toggle)
  );

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wmask = 4'($urandom_range(0, 15));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic er);
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = a;
    cmd_wdata = $urandom;
    tick();
    cmd_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  logic [31:0] rd;
  logic        er;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_read  = 1'b0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b1;
    tm_stop   = 1'b0;
    tick();
    tick();
    check("rst_toggle", {31'd0, rtc_toggle}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;

    // Backpressure: read DIV with rsp_ready low.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h4;
    tick();
    cmd_valid = 1'b0;
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_rdata", rsp_rdata, 32'h1FF);
    check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rdata", rsp_rdata, 32'h1FF);
      check("bp_hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release", {31'd0, rsp_valid}, 32'd0);

    // Back-to-back reads, one per cycle.
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h0;
    tick();
    check("b2b_ctrl_v", {31'd0, rsp_valid}, 32'd1);
    check("b2b_ctrl_d", rsp_rdata, 32'd0);
    cmd_addr = 32'h4;
    tick();
    check("b2b_div_v", {31'd0, rsp_valid}, 32'd1);
    check("b2b_div_d", rsp_rdata, 32'h1FF);
    cmd_addr = 32'h8;
    tick();
    check("b2b_cnt_v", {31'd0, rsp_valid}, 32'd1);
    check("b2b_cnt_d", rsp_rdata, 32'd0);
    cmd_valid = 1'b0;
    tick();
    check("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    // Decode error and ignored CNT write.
    bus_read(32'h10, rd, er);
    check("oor_err", {31'd0, er}, 32'd1);
    check("oor_rdata", rd, 32'd0);
    bus_write(32'h14, 32'h5);
    check("oor_wr_err", {31'd0, rsp_err}, 32'd1);
    bus_read(32'h4, rd, er);
    check("oor_no_side_effect", rd, 32'h1FF);
    bus_write(32'h8, 32'h33);
    check("cnt_wr_err", {31'd0, rsp_err}, 32'd0);
    bus_read(32'h8, rd, er);
    check("cnt_unchanged", rd, 32'd0);

    // DIV=3: toggle every 4 cycles.
    bus_write(32'h4, 32'h3);
    bus_write(32'h0, 32'h1);
    check("div3_start", {31'd0, rtc_toggle}, 32'd0);
    for (int t = 1; t <= 5; t++) begin
      repeat (3) tick();
      check("div3_hold", {31'd0, rtc_toggle}, {31'd0, ~t[0]});
      tick();
      check("div3_edge", {31'd0, rtc_toggle}, {31'd0, t[0]});
    end
    bus_read(32'hC, rd, er);
    check("ticks_5", rd, 32'd5);

    // TICKS clear on a tick edge wins; next tick gives 1.
    repeat (2) tick();
    bus_write(32'hC, 32'hFFFF_FFFF);
    check("clr_edge_toggle", {31'd0, rtc_toggle}, 32'd0);
    bus_read(32'hC, rd, er);
    check("clr_wins", rd, 32'd0);
    repeat (3) tick();
    check("after_clr_toggle", {31'd0, rtc_toggle}, 32'd1);
    bus_read(32'hC, rd, er);
    check("after_clr_ticks", rd, 32'd1);

    // DIV=0 with a 10-cycle tm_stop freeze.
    bus_write(32'h0, 32'h0);
    bus_write(32'hC, 32'h0);
    bus_write(32'h4, 32'h0);
    bus_write(32'h0, 32'h1);
    check("div0_start", {31'd0, rtc_toggle}, 32'd1);
    tick();
    check("div0_e1", {31'd0, rtc_toggle}, 32'd0);
    tick();
    check("div0_e2", {31'd0, rtc_toggle}, 32'd1);
    tick();
    check("div0_e3", {31'd0, rtc_toggle}, 32'd0);
    tm_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("freeze_toggle", {31'd0, rtc_toggle}, 32'd0);
    end
    tm_stop = 1'b0;
    bus_read(32'hC, rd, er);
    check("freeze_ticks", rd, 32'd3);
    check("resume_toggle", {31'd0, rtc_toggle}, 32'd1);
    bus_read(32'hC, rd, er);
    check("resume_ticks", rd, 32'd4);

    // Build cnt=2, TICKS=7, then reset mid-transaction.
    tm_stop = 1'b1;
    bus_write(32'hC, 32'h0);
    tm_stop = 1'b0;
    repeat (7) tick();
    check("pre_rst_toggle", {31'd0, rtc_toggle}, 32'd1);
    tm_stop = 1'b1;
    bus_write(32'h4, 32'h3);
    tm_stop = 1'b0;
    repeat (2) tick();
    tm_stop = 1'b1;
    bus_read(32'h8, rd, er);
    check("pre_rst_cnt", rd, 32'd2);
    bus_read(32'hC, rd, er);
    check("pre_rst_ticks", rd, 32'd7);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'hC;
    tick();
    check("pend_valid", {31'd0, rsp_valid}, 32'd1);
    check("pend_rdata", rsp_rdata, 32'd7);
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h5;
    tick();
    cmd_valid = 1'b0;
    check("mid_rst_toggle", {31'd0, rtc_toggle}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tm_stop = 1'b0;
    bus_read(32'h4, rd, er);
    check("post_rst_div", rd, 32'h1FF);
    bus_read(32'h0, rd, er);
    check("post_rst_ctrl", rd, 32'd0);
    bus_read(32'h8, rd, er);
    check("post_rst_cnt", rd, 32'd0);
    bus_read(32'hC, rd, er);
    check("post_rst_ticks", rd, 32'd0);
    tick();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_subsys_rtc_tickgen.md
E203_SUBSYS_RTC_TICKGEN -- requirements
Module: e203_subsys_rtc_tickgen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, meaning prescaler and divisor width.
REQ-002 The block SHALL have parameter RST_DIV, default 16'd511, meaning divisor value after reset.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 The block SHALL have port tick_icb_cmd_valid, input, 1, meaning command request.
REQ-006 The block SHALL have port tick_icb_cmd_ready, output, 1, meaning command accept.
REQ-007 The block SHALL have port tick_icb_cmd_addr, input, 32, meaning byte address.
REQ-008 The block SHALL have port tick_icb_cmd_read, input, 1, meaning 1 = read, 0 = write.
REQ-009 The block SHALL have port tick_icb_cmd_wdata, input, 32, meaning write data.
REQ-010 The block SHALL have port tick_icb_cmd_wmask, input, 4, meaning byte mask; it is ignored and all writes are full-word.
REQ-011 The block SHALL have port tick_icb_rsp_valid, output, 1, meaning response valid.
REQ-012 The block SHALL have port tick_icb_rsp_ready, input, 1, meaning response accept.
REQ-013 The block SHALL have port tick_icb_rsp_err, output, 1, meaning decode error.
REQ-014 The block SHALL have port tick_icb_rsp_rdata, output, 32, meaning read data.
REQ-015 The block SHALL have port tm_stop, input, 1, meaning freeze the prescaler while high.
REQ-016 The block SHALL have port rtc_toggle, output, 1, meaning the registered square-wave tick; it feeds the CLINT rtcToggle input.

Function
REQ-017 Register map SHALL be decoded on addr[3:2] when addr[11:4]==0:
- 0x0 CTRL: bit0 en; other bits read 0.
- 0x4 DIV: bits[DIV_W-1:0].
- 0x8 CNT: read-only current prescaler value.
- 0xC TICKS: 32-bit count of toggles; any write clears it to 0.
REQ-018 An access with addr[11:4]!=0 SHALL return rsp_err=1 and rdata=0, and SHALL have no register side effect.
REQ-019 A write to CNT SHALL be ignored and SHALL return rsp_err=0.
REQ-020 The prescaler SHALL advance when en=1 and tm_stop=0:
- If cnt==DIV: cnt<=0, rtc_toggle<=~rtc_toggle, TICKS<=TICKS+1 (mod 2^32).
- Otherwise: cnt<=cnt+1.
REQ-021 When en=0 or tm_stop=1, cnt, rtc_toggle and TICKS SHALL hold their values.
REQ-022 With DIV=N, rtc_toggle SHALL have period 2*(N+1) clk cycles; with DIV=0 it SHALL invert every enabled cycle.
REQ-023 An accepted DIV write SHALL load the new divisor and force cnt<=0 on the same edge; no toggle occurs on that edge.
REQ-024 An accepted CTRL write SHALL change en on the accept edge; the first advance under the new value occurs on the following edge.
REQ-025 When a TICKS clear and a tick increment occur on the same edge, TICKS SHALL become 0 (the write wins).
REQ-026 tick_icb_cmd_ready SHALL equal ~rsp_valid | tick_icb_rsp_ready, allowing at most one outstanding response.
REQ-027 On accept (valid & ready):
- rsp_valid<=1 on the next edge.
- rdata and err are registered from the pre-write register state.
- The write takes effect on the accept edge.
REQ-028 rsp_valid SHALL clear on rsp_valid & rsp_ready, unless a new command is accepted in the same cycle, in which case it stays 1.
REQ-029 rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL set:
- en=0, DIV=RST_DIV, cnt=0, TICKS=0
- rtc_toggle=0, rsp_valid=0, rsp_err=0, rsp_rdata=0
REQ-031 A reset asserted mid-transaction SHALL discard the pending response, and the write SHALL not take effect if it is asserted on the accept edge.

Verification
REQ-032 Reset, write DIV=3, write CTRL=1 -> rtc_toggle toggles every 4 cycles (period 8), and TICKS reads 5 after 5 toggles.
REQ-033 Running with DIV=0, pulse tm_stop high for 10 cycles -> rtc_toggle and TICKS frozen for exactly those 10 cycles, then resume.
REQ-034 Write TICKS on the same edge as a tick -> readback is 0, and the next tick yields 1.
REQ-035 Read 0x10 -> rsp_err=1, rdata=0, no state change; write CNT -> rsp_err=0, CNT unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles after a read of DIV -> cmd_ready=0, with rsp_valid and rdata stable (0x1FF after reset); back-to-back reads with rsp_ready=1 complete at one per cycle.
REQ-037 Assert rst_n=0 for one cycle with cnt=2 and TICKS=7 -> all outputs return to their reset values on that edge.
